// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle event decoder and its helpers.
package toggle_pkg;

  typedef enum logic [0:0] {INIT, RUN} state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned PEND_W          = 4;
  // Wide enough to count SYNC_STAGES+1 edges for SYNC_STAGES up to 4.
  localparam int unsigned ARM_W           = 3;

endpackage

// File: rtl/toggle_event_decoder_if.sv
// Consumer-facing event bus: queue status, handshake and counters.
interface toggle_event_decoder_if
  import toggle_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic              evt_ready;
  logic              ovf_clr;
  logic              evt_pulse;
  logic              evt_valid;
  logic [PEND_W-1:0] evt_pending;
  logic [CNT_W-1:0]  evt_count;
  logic              overflow;
  logic              armed;

  modport master (
    input  evt_ready, ovf_clr,
    output evt_pulse, evt_valid, evt_pending, evt_count, overflow, armed
  );

  modport slave (
    output evt_ready, ovf_clr,
    input  evt_pulse, evt_valid, evt_pending, evt_count, overflow, armed
  );
endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];
endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes level changes on an asynchronous toggle line into pulses, a bounded
// event queue with overflow flag, and a free-running event counter.
module toggle_event_decoder
  import toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   toggle_in,
  toggle_event_decoder_if.master bus
);
  logic              sync_lvl;
  state_t            state_q, state_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic              last_lvl_q;
  logic              pulse_q, pulse_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              evt;
  logic              pop;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (toggle_in),
    .q  (sync_lvl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      arm_cnt_q  <= '0;
      last_lvl_q <= 1'b0;
      pulse_q    <= 1'b0;
      pend_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      last_lvl_q <= sync_lvl;
      pulse_q    <= pulse_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    evt       = 1'b0;
    pop       = (pend_q != '0) && bus.evt_ready;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q & ~bus.ovf_clr;

    unique case (state_q)
      // Let the synchronizer flush so the first reference level is settled.
      INIT: begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
        if (arm_cnt_q == ARM_W'(SYNC_STAGES)) begin
          state_d = RUN;
        end
      end
      RUN:     evt = (sync_lvl != last_lvl_q);
      default: state_d = INIT;
    endcase

    pulse_d = evt;
    if (evt) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A simultaneous push and pop cancel out, so a full queue never overflows then.
    if (evt && !pop) begin
      if (pend_q < PEND_W'(DEPTH)) begin
        pend_d = pend_q + PEND_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop && !evt) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  assign bus.evt_pulse   = pulse_q;
  assign bus.evt_valid   = (pend_q != '0);
  assign bus.evt_pending = pend_q;
  assign bus.evt_count   = cnt_q;
  assign bus.overflow    = ovf_q;
  assign bus.armed       = (state_q == RUN);
endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed and random stimulus against an edge-indexed event model.
module tb_toggle_event_decoder;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int MAXE  = 4096;

  logic clk = 1'b0;
  logic rst;
  logic toggle_in;

  always #5 clk = ~clk;

  toggle_event_decoder_if #(.CNT_W(16)) bus16 ();
  toggle_event_decoder_if #(.CNT_W(4))  bus4 ();

  toggle_event_decoder #(
    .SYNC_STAGES(SYNC),
    .DEPTH      (DEPTH),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .toggle_in(toggle_in),
    .bus      (bus16.master)
  );

  toggle_event_decoder #(
    .SYNC_STAGES(SYNC),
    .DEPTH      (DEPTH),
    .CNT_W      (4)
  ) dut_w (
    .clk      (clk),
    .rst      (rst),
    .toggle_in(toggle_in),
    .bus      (bus4.master)
  );

  // Model: an input change first sampled at edge k is reported at edge k+SYNC,
  // provided that edge comes after arming (edge SYNC+1 since release).
  int m_edge;
  int m_pend;
  int m_cnt;
  bit m_ovf;
  bit m_prev;
  bit m_chg[MAXE];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input bit evt);
    check("pulse",    32'(bus16.evt_pulse),   32'(evt));
    check("pending",  32'(bus16.evt_pending), 32'(m_pend));
    check("valid",    32'(bus16.evt_valid),   32'(m_pend != 0));
    check("overflow", 32'(bus16.overflow),    32'(m_ovf));
    check("armed",    32'(bus16.armed),       32'(m_edge >= SYNC + 1));
    check("count16",  32'(bus16.evt_count),   32'(m_cnt) & 32'hFFFF);
    check("count4",   32'(bus4.evt_count),    32'(m_cnt) & 32'hF);
    check("pending4", 32'(bus4.evt_pending),  32'(m_pend));
  endtask

  task automatic set_inputs(input bit rdy, input bit clr);
    bus16.evt_ready = rdy;
    bus4.evt_ready  = rdy;
    bus16.ovf_clr   = clr;
    bus4.ovf_clr    = clr;
  endtask

  task automatic step(input bit flip, input bit rdy, input bit clr);
    int k;
    bit evt, pop, ovf_set;
    toggle_in = toggle_in ^ flip;
    set_inputs(rdy, clr);
    k = m_edge + 1;
    if (k < MAXE) m_chg[k] = (toggle_in != m_prev);
    m_prev = toggle_in;
    @(posedge clk);
    #1;
    m_edge  = k;
    evt     = (k >= SYNC + 2) && (k - SYNC < MAXE) && m_chg[k-SYNC];
    pop     = rdy && (m_pend > 0);
    ovf_set = 1'b0;
    if (evt && !pop) begin
      if (m_pend < DEPTH) m_pend++;
      else ovf_set = 1'b1;
    end else if (pop && !evt) begin
      m_pend--;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (evt) m_cnt++;
    check_all(evt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pulse",   32'(bus16.evt_pulse),   32'd0);
    check("rst_valid",   32'(bus16.evt_valid),   32'd0);
    check("rst_pending", 32'(bus16.evt_pending), 32'd0);
    check("rst_count",   32'(bus16.evt_count),   32'd0);
    check("rst_count4",  32'(bus4.evt_count),    32'd0);
    check("rst_ovf",     32'(bus16.overflow),    32'd0);
    check("rst_armed",   32'(bus16.armed),       32'd0);
    set_inputs(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_edge = 0;
    m_pend = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    foreach (m_chg[i]) m_chg[i] = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    toggle_in = 1'b1;
    set_inputs(1'b0, 1'b0);
    #2;

    // Arming with toggle_in held high through reset.
    do_reset();
    repeat (10) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Single toggle latency.
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Drain, then overflow with five spaced toggles and clear it.
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("ovf_full_pending", 32'(bus16.evt_pending), 32'd4);
    check("ovf_set",          32'(bus16.overflow),    32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("ovf_cleared",      32'(bus16.overflow),    32'd0);

    // Full queue: pop lands on the same edge as a new event.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("simul_pending", 32'(bus16.evt_pending), 32'd4);
    check("simul_ovf",     32'(bus16.overflow),    32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic.
    repeat (300) begin
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end

    // Mid-operation reset with three events queued.
    repeat (8) step(1'b0, 1'b1, 1'b0);
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("pre_rst_pending", 32'(bus16.evt_pending), 32'd3);
    do_reset();
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("rearm_count", 32'(bus16.evt_count), 32'd1);

    // Counter wrap on the narrow instance.
    do_reset();
    repeat (4) step(1'b0, 1'b1, 1'b0);
    repeat (17) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("wrap_count4",  32'(bus4.evt_count),   32'd1);
    check("wrap_pending", 32'(bus4.evt_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/toggle_event_decoder.md
TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on toggle_in, legal range 2..4.
REQ-002 Parameter DEPTH, default 4: maximum number of queued undelivered events, legal range 1..15.
REQ-003 Parameter CNT_W, default 16: width of the total-event counter.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 toggle_in  input  1  toggle-encoded event line, for example the Q of a T flip-flop in another domain; each level change encodes one event; asynchronous to clk.
REQ-007 evt_ready  input  1  consumer accepts the queued event at the head.
REQ-008 ovf_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-009 evt_pulse  output  1  one-cycle strobe per detected level change.
REQ-010 evt_valid  output  1  at least one event is queued.
REQ-011 evt_pending  output  4  number of queued events, 0..DEPTH.
REQ-012 evt_count  output  CNT_W  total events detected since reset, modulo 2^CNT_W.
REQ-013 overflow  output  1  sticky flag: an event was detected while the queue was full.
REQ-014 armed  output  1  high in state RUN.

Function
REQ-015 toggle_in passes through a SYNC_STAGES-deep flop chain; only the chain output (sync_lvl) is used downstream.
REQ-016 The FSM has two states, INIT and RUN; reset enters INIT.
REQ-017 INIT: an arm counter counts SYNC_STAGES+1 clk edges; last_lvl loads sync_lvl on every edge; no events are generated; transition to RUN when the count completes.
REQ-018 RUN: when sync_lvl != last_lvl, an event is detected; last_lvl <= sync_lvl on every edge.
REQ-019 Latency: a toggle_in change that meets setup before edge N drives evt_pulse high for exactly the cycle following edge N+SYNC_STAGES.
REQ-020 evt_pulse is registered and glitch-free; back-to-back toggles on consecutive sampled cycles produce back-to-back pulses.
REQ-021 evt_count increments by 1 on every detected event, including events dropped on overflow, and wraps from all-ones to 0.
REQ-022 evt_valid = (evt_pending != 0); a pop occurs on an edge where evt_valid && evt_ready.
REQ-023 Event with no pop: evt_pending +1 if < DEPTH; otherwise evt_pending holds, overflow <= 1, and the event is dropped.
REQ-024 Pop with no event: evt_pending -1. Event and pop on the same edge: evt_pending unchanged and no overflow, even when full.
REQ-025 evt_ready while evt_valid=0 has no effect; evt_pending never underflows.
REQ-026 ovf_clr clears overflow on the next edge; if ovf_clr and an overflow condition occur on the same edge, overflow = 1 (set wins).
REQ-027 evt_pulse, evt_count and the queue do not change in INIT.

Reset
REQ-028 rst asserted, at any time including mid-event: all outputs go to 0 immediately (evt_pulse, evt_valid, evt_pending, evt_count, overflow, armed), sync chain = 0, last_lvl = 0, state = INIT.
REQ-029 After rst deassertion, a static toggle_in of either level produces no event; only changes after armed=1 are reported.

Structure
REQ-030 Shared package toggle_pkg holds the FSM state enum {INIT, RUN}, the default constants for SYNC_STAGES, DEPTH and CNT_W, and the evt_pending width constant (4).
REQ-031 Single sub-module sync_chain (parameter STAGES; ports clk, rst, d, q) implements the synchronizer and is reusable elsewhere in the codebase.

Verification
REQ-032 Arming: hold toggle_in=1 through reset and 10 cycles -> armed=1 at cycle SYNC_STAGES+1 after release, evt_count=0, evt_pulse never high.
REQ-033 Latency: toggle at edge N with defaults -> single evt_pulse after edge N+2, evt_pending=1, evt_count=1.
REQ-034 Overflow: evt_ready=0, 5 toggles spaced 3 cycles apart with DEPTH=4 -> evt_pending=4, evt_count=5, overflow=1; then ovf_clr for 1 cycle -> overflow=0.
REQ-035 Simultaneous: queue full (4), evt_ready=1 on the same edge as an event -> evt_pending stays 4, overflow stays 0.
REQ-036 Wrap: CNT_W=4, 17 toggles with evt_ready=1 -> evt_count=1, evt_pending=0.
REQ-037 Mid-operation reset: rst pulsed with evt_pending=3 -> all outputs 0 within the reset assertion; a subsequent toggle after re-arm -> evt_count=1.
